// File: rtl/reset_sequencer.sv
// reset_sequencer: ordered, acknowledged per-domain reset release with timeout and watchdog supervision
module reset_sequencer #(
  parameter int STAGES      = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 8,
  parameter int ACK_TIMEOUT = 64,
  parameter int WDT_CYCLES  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stage_ack,
  input  logic              wdt_kick,
  output logic [STAGES-1:0] rst_out_n,
  output logic              ready,
  output logic              fault,
  output logic [3:0]        fault_stage,
  output logic [7:0]        wdt_count
);
  localparam int m1 = HOLD_CYCLES > STAGE_GAP ? HOLD_CYCLES : STAGE_GAP;
  localparam int m2 = ACK_TIMEOUT > WDT_CYCLES ? ACK_TIMEOUT : WDT_CYCLES;
  localparam int maxp = m1 > m2 ? m1 : m2;
  localparam int cw = $clog2(maxp + 1);
  typedef enum logic [2:0] {HOLD, WAIT_ACK, GAP, RUN, FAULT} state_t;
  state_t state;
  logic [cw-1:0] cnt;
  logic [3:0] idx;
  logic [STAGES-1:0] ack_sh, rel;
  assign ack_sh = stage_ack >> idx;
  assign rel = (rst_out_n << 1) | STAGES'(1);
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= HOLD;
      cnt <= '0;
      idx <= '0;
      rst_out_n <= '0;
      ready <= 1'b0;
      fault <= 1'b0;
      fault_stage <= '0;
      wdt_count <= '0;
    end else begin
      case (state)
        HOLD:
          if (cnt == cw'(HOLD_CYCLES - 1)) begin
            rst_out_n <= rel;
            cnt <= '0;
            state <= WAIT_ACK;
          end else cnt <= cnt + cw'(1);
        WAIT_ACK:
          if (ack_sh[0]) begin
            cnt <= '0;
            state <= idx == 4'(STAGES - 1) ? RUN : GAP;
            ready <= idx == 4'(STAGES - 1);
          end else if (cnt == cw'(ACK_TIMEOUT - 1)) begin
            state <= FAULT;
            rst_out_n <= '0;
            fault <= 1'b1;
            fault_stage <= idx;
          end else cnt <= cnt + cw'(1);
        GAP:
          if (cnt == cw'(STAGE_GAP - 1)) begin
            idx <= idx + 4'd1;
            rst_out_n <= rel;
            cnt <= '0;
            state <= WAIT_ACK;
          end else cnt <= cnt + cw'(1);
        RUN:
          if (wdt_kick) cnt <= '0;
          else if (WDT_CYCLES != 0) begin
            if (cnt == cw'(WDT_CYCLES - 1)) begin
              rst_out_n <= '0;
              ready <= 1'b0;
              wdt_count <= wdt_count + {7'd0, wdt_count != 8'hff};
              idx <= '0;
              cnt <= '0;
              state <= HOLD;
            end else cnt <= cnt + cw'(1);
          end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed vectors plus randomized run against a timestamp-based reference model
module tb_reset_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [2:0] stage_ack = '0;
  logic wdt_kick = 1'b0;
  logic [2:0] ro_a, ro_b;
  logic rdy_a, rdy_b, flt_a, flt_b;
  logic [3:0] fs_a, fs_b;
  logic [7:0] wc_a, wc_b;
  int total = 0, bad = 0, e = 0;
  always #5 clk = ~clk;

  reset_sequencer dut_a (.clk(clk), .rst(rst), .stage_ack(stage_ack), .wdt_kick(wdt_kick),
    .rst_out_n(ro_a), .ready(rdy_a), .fault(flt_a), .fault_stage(fs_a), .wdt_count(wc_a));
  reset_sequencer #(.STAGES(3), .HOLD_CYCLES(1), .STAGE_GAP(1), .ACK_TIMEOUT(64), .WDT_CYCLES(4)) dut_b (
    .clk(clk), .rst(rst), .stage_ack(stage_ack), .wdt_kick(wdt_kick),
    .rst_out_n(ro_b), .ready(rdy_b), .fault(flt_b), .fault_stage(fs_b), .wdt_count(wc_b));

  typedef struct {
    int rel, nack, rdy, flt, fst, wc, m, t_rel, t_ack, t_wd;
  } ms_t;
  ms_t ma, mb;

  function automatic ms_t mstep(input ms_t si, input int ed, input bit r, input bit [2:0] a,
                                input bit k, input int hold, input int gap, input int tmo, input int wdt);
    ms_t s = si;
    if (!r) begin
      s = '{default: 0};
      s.m = ed + 1;
    end else if (s.flt != 0) begin
    end else if (s.rdy != 0) begin
      if (k) s.t_wd = ed;
      else if (wdt != 0 && ed == s.t_wd + wdt) begin
        s.rel = 0;
        s.nack = 0;
        s.rdy = 0;
        if (s.wc < 255) s.wc++;
        s.m = ed + 1;
      end
    end else if (s.rel == 0) begin
      if (ed == s.m + hold - 1) begin
        s.rel = 1;
        s.t_rel = ed;
      end
    end else if (s.nack < s.rel) begin
      if (a[s.rel-1]) begin
        s.nack = s.rel;
        s.t_ack = ed;
        if (s.rel == 3) begin
          s.rdy = 1;
          s.t_wd = ed;
        end
      end else if (ed == s.t_rel + tmo) begin
        s.flt = 1;
        s.fst = s.rel - 1;
        s.rel = 0;
      end
    end else if (ed == s.t_ack + gap) begin
      s.rel++;
      s.t_rel = ed;
    end
    return s;
  endfunction

  function automatic logic [16:0] mexp(input ms_t s);
    return {3'((1 << s.rel) - 1), 1'(s.rdy), 1'(s.flt), 4'(s.fst), 8'(s.wc)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at edge %0d: got %0h want %0h", nm, e, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit [2:0] a, input bit k);
    rst = r;
    stage_ack = a;
    wdt_kick = k;
    @(posedge clk);
    e++;
    ma = mstep(ma, e, r, a, k, 16, 8, 64, 1024);
    mb = mstep(mb, e, r, a, k, 1, 1, 64, 4);
    @(negedge clk);
    chk("model_a", 32'({ro_a, rdy_a, flt_a, fs_a, wc_a}), 32'(mexp(ma)));
    chk("model_b", 32'({ro_b, rdy_b, flt_b, fs_b, wc_b}), 32'(mexp(mb)));
  endtask

  task automatic run_to(input int tgt, input bit r, input bit [2:0] a, input bit k);
    while (e < tgt) step(r, a, k);
  endtask

  typedef struct {
    int at;
    logic [2:0] ro;
    logic rdy;
  } vec_t;
  vec_t vt[7];

  initial begin
    int m, tr, x;
    ma = '{default: 0};
    mb = '{default: 0};
    vt[0] = '{14, 3'b000, 1'b0};
    vt[1] = '{15, 3'b001, 1'b0};
    vt[2] = '{23, 3'b001, 1'b0};
    vt[3] = '{24, 3'b011, 1'b0};
    vt[4] = '{32, 3'b011, 1'b0};
    vt[5] = '{33, 3'b111, 1'b0};
    vt[6] = '{34, 3'b111, 1'b1};
    // nominal sequence, acks tied high
    repeat (5) step(0, 3'b111, 0);
    chk("reset_vals", 32'({ro_a, rdy_a, flt_a, fs_a, wc_a}), 32'd0);
    m = e + 1;
    for (int i = 0; i < 7; i++) begin
      run_to(m + vt[i].at, 1, 3'b111, 0);
      chk($sformatf("seq_ro_%0d", vt[i].at), 32'(ro_a), 32'(vt[i].ro));
      chk($sformatf("seq_rdy_%0d", vt[i].at), 32'(rdy_a), 32'(vt[i].rdy));
    end
    run_to(m + 40, 1, 3'b111, 0);
    // stage 1 ack withheld
    repeat (2) step(0, 3'b001, 0);
    m = e + 1;
    run_to(m + 87, 1, 3'b001, 0);
    chk("pre_fault_ro", 32'(ro_a), 32'd3);
    chk("pre_fault", 32'(flt_a), 32'd0);
    step(1, 3'b001, 0);
    chk("fault_ro", 32'(ro_a), 32'd0);
    chk("fault", 32'(flt_a), 32'd1);
    chk("fault_stage", 32'(fs_a), 32'd1);
    repeat (20) step(1, 3'b111, 0);
    chk("fault_sticky", 32'({ro_a, flt_a, fs_a}), 32'({3'b000, 1'b1, 4'd1}));
    step(0, 3'b111, 0);
    chk("fault_clear", 32'(flt_a), 32'd0);
    // ack arrives on the timeout edge itself
    step(0, 3'b000, 0);
    m = e + 1;
    run_to(m + 78, 1, 3'b000, 0);
    step(1, 3'b001, 0);
    chk("bound_nofault", 32'({ro_a, flt_a}), 32'({3'b001, 1'b0}));
    run_to(m + 86, 1, 3'b001, 0);
    chk("bound_gap", 32'(ro_a), 32'd1);
    step(1, 3'b001, 0);
    chk("bound_rel1", 32'(ro_a), 32'd3);
    tr = m + 97;
    run_to(tr, 1, 3'b111, 0);
    chk("bound_ready", 32'(rdy_a), 32'd1);
    // watchdog expiry then re-sequence
    run_to(tr + 1023, 1, 3'b111, 0);
    chk("wdt_pre", 32'({ro_a, rdy_a, wc_a}), 32'({3'b111, 1'b1, 8'd0}));
    step(1, 3'b111, 0);
    chk("wdt_exp", 32'({ro_a, rdy_a, wc_a}), 32'({3'b000, 1'b0, 8'd1}));
    x = e;
    run_to(x + 16, 1, 3'b111, 0);
    chk("wdt_reseq", 32'(ro_a), 32'd1);
    run_to(x + 35, 1, 3'b111, 0);
    chk("wdt_ready", 32'(rdy_a), 32'd1);
    for (int p = 0; p < 10; p++)
      for (int i = 0; i < 1000; i++) step(1, 3'b111, i == 999);
    chk("kick_hold", 32'({rdy_a, wc_a}), 32'({1'b1, 8'd1}));
    // rst mid-GAP and mid-RUN
    step(0, 3'b111, 0);
    m = e + 1;
    run_to(m + 20, 1, 3'b111, 0);
    step(0, 3'b111, 0);
    chk("gap_rst", 32'({ro_a, rdy_a, flt_a, fs_a, wc_a}), 32'd0);
    m = e + 1;
    run_to(m + 15, 1, 3'b111, 0);
    chk("gap_restart", 32'(ro_a), 32'd1);
    run_to(m + 40, 1, 3'b111, 0);
    chk("run_before", 32'(rdy_a), 32'd1);
    step(0, 3'b111, 0);
    chk("run_rst", 32'({ro_a, rdy_a, flt_a, fs_a, wc_a}), 32'd0);
    m = e + 1;
    run_to(m + 15, 1, 3'b111, 0);
    chk("run_restart", 32'(ro_a), 32'd1);
    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      bit [2:0] a;
      for (int b = 0; b < 3; b++) a[b] = $urandom_range(0, 9) < 3;
      step($urandom_range(0, 299) != 0, a, $urandom_range(0, 39) == 0);
    end
    // watchdog counter saturation on the fast instance
    step(0, 3'b111, 0);
    repeat (3000) step(1, 3'b111, 0);
    chk("wdt_sat", 32'(wc_b), 32'd255);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
